mips_muldiv_unit: RTL and testbench

HI/LO multiply-divide unit for mips_cpu_harvard; sits directly downstream of the decode/register-read stage, which issues MULT/MULTU/DIV/DIVU/MTHI/MTLO operations on the two source operands. It holds the architectural HI and LO registers and presents them to the CPU for MFHI/MFLO. Multiply takes one cycle; divide is iterative and multi-cycle. The CPU stalls on busy by gating its clk_enable.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/mips_divider_core.sv | 63 ++++++
 rtl/mips_muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
// The MADD/MSUB op codes are only decoded when MULDIV_MADD_EN is defined.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  // MADDU/MSUBU share the MADD/MSUB codes; the separate op_unsigned qualifier
  // (present only with MULDIV_MADD_EN) set to OP_UNSIGNED selects them.
  localparam logic OP_UNSIGNED = 1'b1;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpMadd  = 3'd6,
    OpMsub  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StDivIter,
    StDivFix
  } state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mips_divider_core.sv
// Iterative restoring divider on unsigned magnitudes, DIV_STEPS quotient bits per step.
// Divisor 0 naturally yields an all-ones quotient and remainder == dividend.
module mips_divider_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int unsigned Iters = XLEN / DIV_STEPS;
  localparam int unsigned CntW  = $clog2(Iters);

  logic [XLEN-1:0] rem_q, quo_q, div_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [CntW-1:0] count_q;
  logic [XLEN:0]   shifted, diff;

  // quo_q starts as the dividend and is shifted out MSB-first as quotient bits shift in.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < int'(DIV_STEPS); i++) begin
      shifted = {rem_d, quo_d[XLEN-1]};
      diff    = shifted - {1'b0, div_q};
      rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_d   = {quo_d[XLEN-2:0], ~diff[XLEN]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
    end else if (load) begin
      rem_q   <= '0;
      quo_q   <= dividend;
      div_q   <= divisor;
      count_q <= '0;
    end else if (step) begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      count_q <= count_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (count_q == CntW'(Iters - 1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply-divide unit: single-cycle multiply, iterative divide, MTHI/MTLO.
// Optional MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module mips_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef MULDIV_MADD_EN
  input  logic            op_unsigned,
`endif
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              mul_signed, div_signed, div_load, div_step, div_last;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   quo, rem;
  op_t               op_dec;

  assign op_dec     = op_t'(op);
  assign div_signed = (op_dec == OpDiv);

  always_comb begin
    mul_signed = (op_dec == OpMult);
`ifdef MULDIV_MADD_EN
    if ((op_dec == OpMadd || op_dec == OpMsub) && op_unsigned != OP_UNSIGNED) mul_signed = 1'b1;
`endif
  end

  // One 64x64 multiplier truncated to 64 bits serves both signed and unsigned forms.
  assign a_ext = {{XLEN{mul_signed & a[XLEN-1]}}, a};
  assign b_ext = {{XLEN{mul_signed & b[XLEN-1]}}, b};
  assign prod  = a_ext * b_ext;

  mips_divider_core #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_val(a, div_signed)),
    .divisor   (abs_val(b, div_signed)),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op_dec)
            OpMthi: hi_d = a;
            OpMtlo: lo_d = a;
            OpMult, OpMultu: begin
              {hi_d, lo_d} = prod;
              done_d       = 1'b1;
            end
            OpDiv, OpDivu: begin
              div_load = 1'b1;
              dbz_d    = (b == '0);
              q_neg_d  = div_signed & (a[XLEN-1] ^ b[XLEN-1]);
              r_neg_d  = div_signed & a[XLEN-1];
              state_d  = StDivIter;
            end
`ifdef MULDIV_MADD_EN
            OpMadd: begin
              {hi_d, lo_d} = {hi_q, lo_q} + prod;
              done_d       = 1'b1;
            end
            OpMsub: begin
              {hi_d, lo_d} = {hi_q, lo_q} - prod;
              done_d       = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      StDivIter: begin
        div_step = 1'b1;
        if (div_last) state_d = StDivFix;
      end
      StDivFix: begin
        // Remainder fixup alone restores hi=a on divide-by-zero.
        hi_d    = r_neg_q ? -rem : rem;
        lo_d    = dbz_q ? DIV_BY_ZERO_LO : (q_neg_q ? -quo : quo);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed table-driven bench for mips_muldiv_unit plus divide corner sequences.
module tb_mips_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned Steps     = 1;
  localparam int          DivCycles = 32 / Steps + 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
`ifdef MULDIV_MADD_EN
  logic        op_unsigned = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        done;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } dvec_t;

  vec_t  sv[10];
  dvec_t dv[7];

  mips_muldiv_unit #(
    .DIV_STEPS(Steps)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef MULDIV_MADD_EN
    .op_unsigned(op_unsigned),
`endif
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic run_single(input int idx);
    @(negedge clk);
    start = 1'b1; op = sv[idx].op; a = sv[idx].a; b = sv[idx].b;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_hi", idx), hi, sv[idx].hi);
    check($sformatf("v%0d_lo", idx), lo, sv[idx].lo);
    check($sformatf("v%0d_done", idx), 32'(done), 32'(sv[idx].done));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'h0);
    @(negedge clk);
    check($sformatf("v%0d_done_cleared", idx), 32'(done), 32'h0);
  endtask

  task automatic run_div(input int idx, input bit poke);
    int          cycles;
    logic [31:0] prev_hi;
    prev_hi = '0;
    @(negedge clk);
    start = 1'b1; op = dv[idx].op; a = dv[idx].a; b = dv[idx].b;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (poke && cycles == 5) begin
        prev_hi = hi;
        start = 1'b1; op = 3'(OpMthi); a = 32'h0000_1234;
      end
      if (poke && cycles == 6) begin
        start = 1'b0;
        check("busy_mthi_ignored", hi, prev_hi);
      end
      if (done) check($sformatf("d%0d_early_done", idx), 32'(done), 32'h0);
      @(negedge clk);
    end
    check($sformatf("d%0d_latency", idx), 32'(cycles), 32'(DivCycles));
    check($sformatf("d%0d_done", idx), 32'(done), 32'h1);
    check($sformatf("d%0d_hi", idx), hi, dv[idx].hi);
    check($sformatf("d%0d_lo", idx), lo, dv[idx].lo);
    @(negedge clk);
    check($sformatf("d%0d_done_cleared", idx), 32'(done), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw_done;

    sv[0] = '{3'(OpMthi),  32'h0000_0020, 32'h0,          32'h0000_0020, 32'h0000_0000, 1'b0};
    sv[1] = '{3'(OpMtlo),  32'h0000_0040, 32'h0,          32'h0000_0020, 32'h0000_0040, 1'b0};
    sv[2] = '{3'(OpMultu), 32'h0000_0020, 32'h0000_0040, 32'h0000_0000, 32'h0000_0800, 1'b1};
    sv[3] = '{3'(OpMult),  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    sv[4] = '{3'(OpMultu), 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
    sv[5] = '{3'(OpMult),  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b1};
    sv[6] = '{3'(OpMult),  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 1'b1};
`ifdef MULDIV_MADD_EN
    sv[7] = '{3'(OpMadd),  32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0032, 1'b1};
`else
    sv[7] = '{3'(OpMadd),  32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_000F, 1'b0};
`endif
    sv[8] = '{3'(OpMultu), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1};
    sv[9] = '{3'(OpMult),  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};

    dv[0] = '{3'(OpDiv),  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dv[1] = '{3'(OpDivu), 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF};
    dv[2] = '{3'(OpDiv),  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    dv[3] = '{3'(OpDiv),  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    dv[4] = '{3'(OpDivu), 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    dv[5] = '{3'(OpDiv),  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    dv[6] = '{3'(OpDivu), 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    for (int i = 0; i < 10; i++) run_single(i);
    run_div(0, 1'b1);
    for (int i = 1; i < 7; i++) run_div(i, 1'b0);

    // Reset in the middle of a divide aborts it without a result.
    @(negedge clk);
    start = 1'b1; op = 3'(OpDivu); a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before_reset", 32'(busy), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_done", 32'(done), 32'h0);
    saw_done = 0;
    for (int i = 0; i < DivCycles + 5; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort_no_late_done", 32'(saw_done), 32'h0);
    run_div(6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
